// File: rtl/sqrt_arb_pkg.sv
// Shared types and constants for the square-root sharing arbiter.
// State encoding, pointer-width helper and default pipe/FIFO sizes.
package sqrt_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } arb_state_e;

  localparam int SQRT_LAT_DEF  = 17;
  localparam int RES_DEPTH_DEF = 4;

  // Bits needed to index v items; never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sqrt_res_fifo.sv
// Per-requester result FIFO holding {root, rem} pairs.
// Synchronous clear empties it in one cycle.
module sqrt_res_fifo
  import sqrt_arb_pkg::*;
#(
  parameter int Q_WIDTH = 16,
  parameter int R_WIDTH = 17,
  parameter int DEPTH   = RES_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [Q_WIDTH-1:0] root_in,
  input  logic [R_WIDTH-1:0] rem_in,
  input  logic               pop,
  input  logic               clear,
  output logic               empty,
  output logic [Q_WIDTH-1:0] root_out,
  output logic [R_WIDTH-1:0] rem_out
);

  localparam int AW = clog2(DEPTH);
  localparam int EW = Q_WIDTH + R_WIDTH;

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {root_in, rem_in};
  end

  // read/write pointers with extra wrap bit
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign {root_out, rem_out} = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sqrt_share_arb.sv
// Round-robin share of one pipelined sqrt unit among N_REQ requesters.
// Optional SQRT_ARB_STATS_EN adds saturating per-requester grant counters.
module sqrt_share_arb
  import sqrt_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int D_WIDTH   = 32,
  parameter int Q_WIDTH   = D_WIDTH/2,
  parameter int R_WIDTH   = D_WIDTH/2+1,
  parameter int SQRT_LAT  = D_WIDTH/2+1,
  parameter int RES_DEPTH = RES_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           res_valid,
  input  logic [N_REQ-1:0]           res_ready,
  output logic [N_REQ*Q_WIDTH-1:0]   res_root,
  output logic [N_REQ*R_WIDTH-1:0]   res_rem,
  output logic                       sq_vaild,
  output logic [D_WIDTH-1:0]         sq_data,
  input  logic                       sq_o_vaild,
  input  logic [Q_WIDTH-1:0]         sq_root,
  input  logic [R_WIDTH-1:0]         sq_rem,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       tag_err
`ifdef SQRT_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]        stat_grants
`endif
);

  localparam int IW = clog2(N_REQ);
  localparam int CW = clog2(RES_DEPTH+1);
  localparam logic [CW-1:0] FULL_CRED = CW'(RES_DEPTH);

  arb_state_e state, state_nxt;
  logic run, clr, drained;

  logic [IW-1:0]    rr_ptr, gnt_id, issue_id;
  logic [CW-1:0]    credit [N_REQ];
  logic [N_REQ-1:0] elig, grant, pop, push, empty;
  logic             any_gnt;

  logic [SQRT_LAT-1:0]         tag_vld;
  logic [SQRT_LAT-1:0][IW-1:0] tag_id;
  logic                        tag_out;
  logic [IW-1:0]               tag_out_id;
  logic                        wr_en;

  function automatic int wrap(input int v);
    return (v >= N_REQ) ? v - N_REQ : v;
  endfunction

  // flush FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // next state and state-decoded controls
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    clr       = 1'b0;
    unique case (state)
      RUN: begin
        run = 1'b1;
        if (flush) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drained) state_nxt = CLEAR;
      end
      CLEAR: begin
        clr       = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign flush_done = clr;

  // eligible: offering, holds a credit, arbiter running
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] && (credit[i] != '0)
                && run && !rst;
    end
  end

  // round-robin pick starting at rr_ptr
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_gnt && elig[wrap(int'(rr_ptr) + k)]) begin
        grant[wrap(int'(rr_ptr) + k)] = 1'b1;
        gnt_id  = IW'(wrap(int'(rr_ptr) + k));
        any_gnt = 1'b1;
      end
    end
  end

  assign req_ready = grant;
  assign res_valid = ~empty;
  assign pop       = res_valid & res_ready;

  // issue register feeding the root pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_vaild <= 1'b0;
      sq_data  <= '0;
      issue_id <= '0;
    end else begin
      sq_vaild <= any_gnt;
      if (any_gnt) begin
        sq_data  <= req_data[int'(gnt_id)*D_WIDTH +: D_WIDTH];
        issue_id <= gnt_id;
      end
    end
  end

  // rr pointer and credits; grant+pop on one requester nets out
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rr_ptr <= '0;
      for (int i = 0; i < N_REQ; i++) credit[i] <= FULL_CRED;
    end else begin
      if (any_gnt) rr_ptr <= IW'(wrap(int'(gnt_id) + 1));
      for (int i = 0; i < N_REQ; i++) begin
        unique case ({grant[i], pop[i]})
          2'b10:   credit[i] <= credit[i] - 1'b1;
          2'b01:   credit[i] <= credit[i] + 1'b1;
          default: credit[i] <= credit[i];
        endcase
      end
    end
  end

  // owner tags, last stage lines up with sq_o_vaild
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[SQRT_LAT-2:0], sq_vaild};
      tag_id  <= {tag_id[SQRT_LAT-2:0], issue_id};
    end
  end

  assign tag_out    = tag_vld[SQRT_LAT-1];
  assign tag_out_id = tag_id[SQRT_LAT-1];
  assign drained    = !sq_vaild && (tag_vld == '0);
  assign wr_en      = sq_o_vaild && tag_out;

  always_comb begin
    push = '0;
    for (int i = 0; i < N_REQ; i++) begin
      push[i] = wr_en && (tag_out_id == IW'(i));
    end
  end

  // sticky pipe/tag disagreement flag
  always_ff @(posedge clk) begin
    if (rst)                       tag_err <= 1'b0;
    else if (sq_o_vaild ^ tag_out) tag_err <= 1'b1;
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
    sqrt_res_fifo #(
      .Q_WIDTH (Q_WIDTH),
      .R_WIDTH (R_WIDTH),
      .DEPTH   (RES_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[g]),
      .root_in  (sq_root),
      .rem_in   (sq_rem),
      .pop      (pop[g]),
      .clear    (clr),
      .empty    (empty[g]),
      .root_out (res_root[g*Q_WIDTH +: Q_WIDTH]),
      .rem_out  (res_rem[g*R_WIDTH +: R_WIDTH])
    );
  end

`ifdef SQRT_ARB_STATS_EN
  logic [15:0] gcnt [N_REQ];

  // saturating grant counters
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < N_REQ; i++) gcnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && gcnt[i] != 16'hFFFF)
          gcnt[i] <= gcnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = gcnt[g];
  end
`endif

endmodule

// File: tb/tb_sqrt_share_arb.sv
// Directed bench for sqrt_share_arb with a behavioural root pipe.
// Define SQRT_ARB_STATS_EN to also exercise the grant counters.
module tb_sqrt_share_arb;

  localparam int LAT = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic [1:0]  res_valid;
  logic [1:0]  res_ready;
  logic [31:0] res_root;
  logic [33:0] res_rem;
  logic        sq_vaild;
  logic [31:0] sq_data;
  logic        sq_o_vaild;
  logic [15:0] sq_root;
  logic [16:0] sq_rem;
  logic        flush;
  logic        flush_done;
  logic        tag_err;
  logic        inject;
`ifdef SQRT_ARB_STATS_EN
  logic [31:0] stat_grants;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int sq_cnt = 0;

  always #5 clk = ~clk;

  sqrt_share_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_root   (res_root),
    .res_rem    (res_rem),
    .sq_vaild   (sq_vaild),
    .sq_data    (sq_data),
    .sq_o_vaild (sq_o_vaild),
    .sq_root    (sq_root),
    .sq_rem     (sq_rem),
    .flush      (flush),
    .flush_done (flush_done),
    .tag_err    (tag_err)
`ifdef SQRT_ARB_STATS_EN
    ,
    .stat_grants(stat_grants)
`endif
  );

  // behavioural root pipe, LAT cycles deep, shares rst
  function automatic logic [15:0] f_root(input logic [31:0] x);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (64'(t) * 64'(t) <= 64'(x)) r = t;
    end
    return r[15:0];
  endfunction

  function automatic logic [16:0] f_rem(input logic [31:0] x);
    logic [63:0] r;
    logic [63:0] d;
    r = 64'(f_root(x));
    d = 64'(x) - r * r;
    return d[16:0];
  endfunction

  logic [LAT-1:0]       pv;
  logic [LAT-1:0][31:0] pd;

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      pd <= '0;
    end else begin
      pv <= {pv[LAT-2:0], sq_vaild};
      pd <= {pd[LAT-2:0], sq_data};
      if (pv[LAT-1]) sq_cnt <= sq_cnt + 1;
    end
  end

  assign sq_o_vaild = pv[LAT-1] | inject;
  assign sq_root    = f_root(pd[LAT-1]);
  assign sq_rem     = f_rem(pd[LAT-1]);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    res_ready = '0;
    flush = 1'b0;
    inject = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] d;
    logic [15:0] root;
    logic [16:0] rem;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr, nd, ndone, n0, n1;
    int base;
    bit seen, sawv;
    logic [1:0] gexp [8];

    tbl[0] = '{32'd144,        16'd12,    17'd0};
    tbl[1] = '{32'd150,        16'd12,    17'd6};
    tbl[2] = '{32'd0,          16'd0,     17'd0};
    tbl[3] = '{32'd1,          16'd1,     17'd0};
    tbl[4] = '{32'd2,          16'd1,     17'd1};
    tbl[5] = '{32'd1000000,    16'd1000,  17'd0};
    tbl[6] = '{32'd999999,     16'd999,   17'd1998};
    tbl[7] = '{32'hFFFF_FFFF,  16'd65535, 17'd131070};
    tbl[8] = '{32'd65536,      16'd256,   17'd0};
    tbl[9] = '{32'd4294836225, 16'd65535, 17'd0};
    gexp = '{2'b01, 2'b10, 2'b01, 2'b10,
             2'b01, 2'b10, 2'b01, 2'b10};

    req_data = '0;
    // reset state
    rst = 1'b1;
    req_valid = 2'b11;
    res_ready = '0;
    flush = 1'b0;
    inject = 1'b0;
    step();
    step();
    #1;
    chk("rst_ready", req_ready, 2'b00);
    rst = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_sqv", sq_vaild, 0);
    chk("rst_resv", res_valid, 2'b00);
    chk("rst_done", flush_done, 0);
    chk("rst_err", tag_err, 0);

    // 1: single requester, table of operands
    for (int v = 0; v < 10; v++) begin
      req_data[31:0] = tbl[v].d;
      req_valid = 2'b01;
      #1;
      chk("t1_ready", req_ready, 2'b01);
      step();
      req_valid = '0;
      chk("t1_sqv", sq_vaild, 1);
      chk("t1_sqd", sq_data, tbl[v].d);
      repeat (17) step();
      chk("t1_early", res_valid, 2'b00);
      step();
      chk("t1_resv", res_valid, 2'b01);
      chk("t1_root", res_root[15:0], tbl[v].root);
      chk("t1_rem", res_rem[16:0], tbl[v].rem);
      res_ready = 2'b01;
      step();
      res_ready = '0;
      #1;
      chk("t1_pop", res_valid, 2'b00);
    end

    // 2: both requesters, alternating grants
    do_reset();
    req_data = {32'hFFFF_FFFF, 32'd144};
    req_valid = 2'b11;
    res_ready = 2'b11;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("t2_alt", req_ready, gexp[c]);
      step();
    end
    #1;
    chk("t2_nocred", req_ready, 2'b00);
    req_valid = '0;
    for (int c = 0; c < 40 && !res_valid[1]; c++) step();
    chk("t2_got1", res_valid[1], 1);
    chk("t2_root1", res_root[31:16], 16'd65535);
    chk("t2_rem1", res_rem[33:17], 17'd131070);
    repeat (30) step();

    // 3: credit exhaustion on req0
    do_reset();
    req_data = {32'd25, 32'd16};
    req_valid = 2'b11;
    res_ready = 2'b10;
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_ready[0]) n0++;
      if (req_ready[1]) n1++;
      step();
    end
    chk("t3_n0", n0, 4);
    chk("t3_n1_served", (n1 > 4), 1);
    #1;
    chk("t3_blocked", req_ready[0], 0);
    chk("t3_held", res_valid[0], 1);
    res_ready = 2'b11;
    step();
    res_ready = 2'b10;
    n0 = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (req_ready[0]) n0++;
      step();
    end
    chk("t3_one_more", n0, 1);
    req_valid = '0;
    res_ready = 2'b11;
    repeat (40) step();

    // 4: flush with operands in flight
    do_reset();
    base = sq_cnt;
    req_data = {32'd49, 32'd64};
    req_valid = 2'b11;
    res_ready = 2'b11;
    ngr = 0;
    for (int c = 0; c < 60 && ngr < 10; c++) begin
      #1;
      if (|req_ready) ngr++;
      step();
    end
    chk("t4_grants", ngr, 10);
    req_valid = '0;
    res_ready = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    req_valid = 2'b11;
    nd = 0;
    ndone = 0;
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      #1;
      if (|req_ready) nd++;
      if (flush_done) begin
        seen = 1;
        ndone++;
        chk("t4_fifo_held", res_valid, 2'b11);
        chk("t4_landed", sq_cnt - base, 10);
        req_valid = 2'b01;
      end
      step();
    end
    chk("t4_done_seen", seen, 1);
    chk("t4_no_drain_gnt", nd, 0);
    #1;
    chk("t4_cleared", res_valid, 2'b00);
    n0 = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (req_ready[0]) n0++;
      if (flush_done) ndone++;
      step();
    end
    chk("t4_credits", n0, 4);
    chk("t4_one_pulse", ndone, 1);
    chk("t4_err", tag_err, 0);

    // 5: reset with traffic in flight
    do_reset();
    req_data = {32'd81, 32'd100};
    req_valid = 2'b11;
    repeat (25) step();
    chk("t5_pre", res_valid, 2'b11);
    rst = 1'b1;
    step();
    chk("t5_sqv", sq_vaild, 0);
    chk("t5_resv", res_valid, 2'b00);
    chk("t5_ready", req_ready, 2'b00);
    chk("t5_sqd", sq_data, 0);
    rst = 1'b0;
    req_valid = '0;
    sawv = 0;
    for (int c = 0; c < 30; c++) begin
      if (|res_valid) sawv = 1;
      step();
    end
    chk("t5_no_stale", sawv, 0);
    chk("t5_err", tag_err, 0);
    req_valid = 2'b01;
    n0 = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (req_ready[0]) n0++;
      step();
    end
    chk("t5_credits", n0, 4);

    // 6: stray result with empty tag register
    req_valid = '0;
    res_ready = 2'b11;
    repeat (25) step();
    chk("t6_idle", res_valid, 2'b00);
    chk("t6_pre_err", tag_err, 0);
    res_ready = '0;
    inject = 1'b1;
    step();
    inject = 1'b0;
    chk("t6_err", tag_err, 1);
    repeat (5) step();
    chk("t6_sticky", tag_err, 1);
    chk("t6_no_write", res_valid, 2'b00);
    do_reset();
    #1;
    chk("t6_rst_clr", tag_err, 0);

`ifdef SQRT_ARB_STATS_EN
    // 7: grant counters
    do_reset();
    req_data = {32'd9, 32'd0};
    req_valid = 2'b10;
    res_ready = 2'b10;
    n1 = 0;
    for (int c = 0; c < 1000 && n1 < 100; c++) begin
      #1;
      if (req_ready[1]) n1++;
      if (n1 == 100) req_valid = '0;
      step();
    end
    req_valid = '0;
    chk("t7_n1", n1, 100);
    chk("t7_stat1", stat_grants[31:16], 16'd100);
    chk("t7_stat0", stat_grants[15:0], 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
